// File: rtl/brush_stamper.sv
// brush_stamper: rasterises a square brush and its mirrored copies into single-pixel framebuffer writes
//   clk, rst_n (sync, active-low)
//   start, cursor_x, cursor_y, brush_size, symmetry_mode, color : burst request and its settings
//   wr_valid/wr_ready, wr_x, wr_y, wr_color                      : framebuffer write stream
//   busy, done                                                  : burst status
module brush_stamper #(
  parameter int CANVAS_W = 160,
  parameter int CANVAS_H = 120,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] cursor_x,
  input  logic [YW-1:0] cursor_y,
  input  logic [2:0]    brush_size,
  input  logic [1:0]    symmetry_mode,
  input  logic [CW-1:0] color,
  input  logic          wr_ready,
  output logic          wr_valid,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [CW-1:0] wr_color,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [XW-1:0] lx;
  logic [YW-1:0] ly;
  logic [2:0] lsize, px, py, npx, npy;
  logic [1:0] lmode, cp, nc, nxt_c;
  logic [3:0] en;
  logic first, adv, has_c, row_end, col_end, last, clip;
  logic [XW:0] bx, mxf;
  logic [YW:0] by, myf;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (adv && last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  // Position following the current one; in IDLE this is position 0 built from the live inputs,
  // so the first pixel can be registered on the same edge that accepts start.
  always_comb begin
    first = state == IDLE;
    adv = !wr_valid || wr_ready;
    en = {lmode == 2'd3, lmode[1], lmode[0], 1'b1};
    nxt_c = 2'd0;
    has_c = 1'b0;
    for (int i = 3; i > 0; i--)
      if (i > int'(cp) && en[i]) begin
        nxt_c = 2'(i);
        has_c = 1'b1;
      end
    row_end = px == lsize;
    col_end = py == lsize;
    last = row_end && col_end && !has_c;
    nc = first ? 2'd0 : (row_end && col_end) ? nxt_c : cp;
    npx = (first || row_end) ? 3'd0 : px + 3'd1;
    npy = (first || (row_end && col_end)) ? 3'd0 : row_end ? py + 3'd1 : py;
    bx = {1'b0, first ? cursor_x : lx} + (XW+1)'(npx);
    by = {1'b0, first ? cursor_y : ly} + (YW+1)'(npy);
    clip = bx >= (XW+1)'(CANVAS_W) || by >= (YW+1)'(CANVAS_H);
    mxf = (XW+1)'(CANVAS_W - 1) - bx;
    myf = (YW+1)'(CANVAS_H - 1) - by;
    nx = XW'(nc[0] ? mxf : bx);
    ny = YW'(nc[1] ? myf : by);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lx <= '0;
      ly <= '0;
      lsize <= '0;
      lmode <= '0;
      cp <= '0;
      px <= '0;
      py <= '0;
      wr_valid <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_color <= '0;
    end else if (state == IDLE && start) begin
      lx <= cursor_x;
      ly <= cursor_y;
      lsize <= brush_size;
      lmode <= symmetry_mode;
      wr_color <= color;
      cp <= nc;
      px <= npx;
      py <= npy;
      wr_valid <= !clip;
      wr_x <= nx;
      wr_y <= ny;
    end else if (state == RUN && adv) begin
      cp <= nc;
      px <= npx;
      py <= npy;
      wr_valid <= !last && !clip;
      wr_x <= nx;
      wr_y <= ny;
    end
  end
endmodule
